// File: rtl/led_matrix_scan_driver_pkg.sv
// Shared types and helpers for the LED matrix scan driver.
package led_scan_pkg;

   typedef enum logic [1:0] {
      BLANK,
      ON,
      OFF
   } scan_state_t;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) r++;
      return (r == 0) ? 1 : r;
   endfunction

   function automatic logic act_anode(input logic on, input logic act_high);
      return act_high ? on : ~on;
   endfunction

   function automatic logic act_cathode(input logic on, input logic act_low);
      return act_low ? ~on : on;
   endfunction

endpackage

// File: rtl/led_matrix_scan_driver_tick_gen.sv
// Clock-enable prescaler: one-cycle tick every DIV clk_i cycles, no derived clock.
module scan_tick_gen
   import led_scan_pkg::*;
#(
   parameter int unsigned DIV = 50000
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic tick_o
);

   localparam int unsigned CW = clog2(DIV);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == CW'(DIV - 1));

   always_comb begin
      cnt_d = tick_o ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/led_matrix_scan_driver.sv
// Row-scanning LED matrix driver: double-buffered frame store, per-row blanking,
// global PWM brightness, all scan state advanced on the prescaler tick.
module led_matrix_scan_driver
   import led_scan_pkg::*;
#(
   parameter int unsigned ROWS            = 8,
   parameter int unsigned COLS            = 8,
   parameter int unsigned DIV             = 50000,
   parameter int unsigned BLANK_TICKS     = 1,
   parameter int unsigned BW              = 3,
   parameter bit          ANODE_ACT_HIGH  = 1'b1,
   parameter bit          CATHODE_ACT_LOW = 1'b1
) (
   input  logic                   clk_in,
   input  logic                   reset,
   input  logic                   wr_en,
   input  logic [clog2(ROWS)-1:0] wr_row,
   input  logic [COLS-1:0]        wr_data,
   input  logic                   commit,
   input  logic [BW-1:0]          brightness,
   output logic                   commit_pending,
   output logic                   frame_start,
   output logic [ROWS-1:0]        out_anode,
   output logic [COLS-1:0]        out_cathode
);

   localparam int unsigned     RW           = clog2(ROWS);
   localparam int unsigned     PWM_MAX      = (32'd1 << BW) - 32'd1;
   localparam logic [ROWS-1:0] ANODE_IDLE   = {ROWS{act_anode(1'b0, ANODE_ACT_HIGH)}};
   localparam logic [COLS-1:0] CATHODE_IDLE = {COLS{act_cathode(1'b0, CATHODE_ACT_LOW)}};

   logic tick;

   scan_tick_gen #(.DIV(DIV)) u_tick (
      .clk_i (clk_in),
      .rst_i (reset),
      .tick_o(tick)
   );

   scan_state_t     state_q, state_d;
   logic [RW-1:0]   row_q, row_d;
   logic [31:0]     cnt_q, cnt_d;
   logic [31:0]     lvl;
   logic [BW-1:0]   b_q, b_d;
   logic            pending_q, pending_d;
   logic            first_q;
   logic            fs_q, fs_d;
   logic            swap, next_row;
   logic [ROWS-1:0] anode_q, anode_d;
   logic [COLS-1:0] cathode_q, cathode_d;
   logic [COLS-1:0] shadow_q [ROWS];
   logic [COLS-1:0] active_q [ROWS];

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      cnt_d    = cnt_q;
      b_d      = b_q;
      fs_d     = 1'b0;
      swap     = 1'b0;
      next_row = 1'b0;
      lvl      = 32'(b_q);

      // The first cycle after reset counts as entering row 0's BLANK.
      if (first_q) begin
         b_d  = brightness;
         fs_d = 1'b1;
      end else if (tick) begin
         case (state_q)
            BLANK: begin
               if (cnt_q == BLANK_TICKS - 32'd1) begin
                  cnt_d   = '0;
                  state_d = (lvl != 32'd0) ? ON : OFF;
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end
            ON: begin
               if (cnt_q == lvl - 32'd1) begin
                  cnt_d = '0;
                  if (lvl == PWM_MAX) next_row = 1'b1;
                  else                state_d  = OFF;
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end
            OFF: begin
               if (cnt_q == PWM_MAX - lvl - 32'd1) begin
                  cnt_d    = '0;
                  next_row = 1'b1;
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end
            default: state_d = BLANK;
         endcase

         if (next_row) begin
            state_d = BLANK;
            b_d     = brightness;
            if (row_q == RW'(ROWS - 1)) begin
               row_d = '0;
               fs_d  = 1'b1;
               swap  = pending_q;
            end else begin
               row_d = row_q + RW'(1);
            end
         end
      end

      // Commit on the swap edge re-arms for the following frame.
      pending_d = commit | (pending_q & ~swap);

      anode_d   = ANODE_IDLE;
      cathode_d = CATHODE_IDLE;
      for (int unsigned r = 0; r < ROWS; r++)
         anode_d[r] = act_anode((state_d == ON) && (row_d == RW'(r)), ANODE_ACT_HIGH);
      for (int unsigned c = 0; c < COLS; c++)
         cathode_d[c] = act_cathode((state_d == ON) && active_q[row_d][c], CATHODE_ACT_LOW);
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q   <= BLANK;
         row_q     <= '0;
         cnt_q     <= '0;
         b_q       <= '0;
         pending_q <= 1'b0;
         first_q   <= 1'b1;
         fs_q      <= 1'b0;
         anode_q   <= ANODE_IDLE;
         cathode_q <= CATHODE_IDLE;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         cnt_q     <= cnt_d;
         b_q       <= b_d;
         pending_q <= pending_d;
         first_q   <= 1'b0;
         fs_q      <= fs_d;
         anode_q   <= anode_d;
         cathode_q <= cathode_d;
      end
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         for (int unsigned r = 0; r < ROWS; r++) begin
            shadow_q[r] <= '0;
            active_q[r] <= '0;
         end
      end else begin
         if (swap) begin
            for (int unsigned r = 0; r < ROWS; r++) active_q[r] <= shadow_q[r];
         end
         if (wr_en && (32'(wr_row) < ROWS)) shadow_q[wr_row] <= wr_data;
      end
   end

   assign commit_pending = pending_q;
   assign frame_start    = fs_q;
   assign out_anode      = anode_q;
   assign out_cathode    = cathode_q;

endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// Self-checking bench for led_matrix_scan_driver against a tick-position reference model.
module tb_led_matrix_scan_driver;

   localparam int ROWS      = 8;
   localparam int COLS      = 8;
   localparam int DIV       = 4;
   localparam int BT        = 1;
   localparam int BW        = 2;
   localparam int PWM_MAX   = 3;
   localparam int SLOT      = BT + PWM_MAX;
   localparam int FRAME     = ROWS * SLOT;
   localparam int FRAME_CYC = FRAME * DIV;

   logic       clk_in = 1'b0;
   logic       reset = 1'b1;
   logic       wr_en = 1'b0;
   logic       commit = 1'b0;
   logic [2:0] wr_row = '0;
   logic [7:0] wr_data = '0;
   logic [1:0] brightness = '0;
   logic       commit_pending, frame_start;
   logic [7:0] out_anode, out_cathode;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc++;

   led_matrix_scan_driver #(
      .ROWS(8), .COLS(8), .DIV(4), .BLANK_TICKS(1), .BW(2),
      .ANODE_ACT_HIGH(1'b1), .CATHODE_ACT_LOW(1'b1)
   ) dut (
      .clk_in(clk_in), .reset(reset), .wr_en(wr_en), .wr_row(wr_row),
      .wr_data(wr_data), .commit(commit), .brightness(brightness),
      .commit_pending(commit_pending), .frame_start(frame_start),
      .out_anode(out_anode), .out_cathode(out_cathode)
   );

   // Reference model: position in the frame follows from the tick count since release.
   int         n, m_b, m_k, m_p, m_row, m_s;
   bit         m_tick, m_swp;
   logic       m_pending;
   logic [7:0] m_shadow [ROWS];
   logic [7:0] m_active [ROWS];
   logic [7:0] exp_anode, exp_cathode;
   logic       exp_fs;

   always @(posedge clk_in or posedge reset) begin
      if (reset) begin
         n = 0; m_b = 0; m_pending = 1'b0;
         for (int r = 0; r < ROWS; r++) begin m_shadow[r] = '0; m_active[r] = '0; end
         exp_anode = 8'h00; exp_cathode = 8'hFF; exp_fs = 1'b0;
      end else begin
         n++;
         m_tick = (n % DIV) == 0;
         m_k    = n / DIV;
         m_p    = m_k % FRAME;
         m_row  = m_p / SLOT;
         m_s    = m_p % SLOT;
         m_swp  = m_tick && (m_p == 0) && m_pending;
         if (m_swp) for (int r = 0; r < ROWS; r++) m_active[r] = m_shadow[r];
         if (wr_en) m_shadow[wr_row] = wr_data;
         m_pending = commit || (m_pending && !m_swp);
         if (n == 1 || (m_tick && m_s == 0)) m_b = int'(brightness);
         exp_fs = (n == 1) || (m_tick && m_p == 0);
         if (m_s >= BT && m_s < BT + m_b) begin
            exp_anode   = 8'd1 << m_row;
            exp_cathode = ~m_active[m_row];
         end else begin
            exp_anode   = 8'h00;
            exp_cathode = 8'hFF;
         end
      end
   end

   task automatic set_idle();
      wr_en = 1'b0; commit = 1'b0; wr_row = '0; wr_data = '0;
   endtask

   task automatic wait_fs(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_in);
         if (frame_start === 1'b1) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; set_idle(); brightness = 2'd3;
      repeat (3) @(negedge clk_in);
      checks++; if (out_anode !== 8'h00) begin errors++; $display("FAIL reset_anode got=%h want=00", out_anode); end
      checks++; if (out_cathode !== 8'hFF) begin errors++; $display("FAIL reset_cathode got=%h want=FF", out_cathode); end
      checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got=%b want=0", commit_pending); end
      checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got=%b want=0", frame_start); end
      reset = 1'b0;
      @(negedge clk_in);
      checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL fs_after_release got=%b want=1", frame_start); end
      @(negedge clk_in);
      checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL fs_one_cycle got=%b want=0", frame_start); end
   endtask

   task automatic test_frame_period();
      bit ok;
      int t1, t2, t3;
      wait_fs(300, ok); t1 = cyc;
      wait_fs(300, ok); t2 = cyc;
      checks++; if (!ok || (t2 - t1) != FRAME_CYC) begin errors++; $display("FAIL fs_period1 got=%0d want=%0d", t2 - t1, FRAME_CYC); end
      wait_fs(300, ok); t3 = cyc;
      checks++; if (!ok || (t3 - t2) != FRAME_CYC) begin errors++; $display("FAIL fs_period2 got=%0d want=%0d", t3 - t2, FRAME_CYC); end
   endtask

   task automatic test_row3_pattern();
      bit ok;
      int lit, i0, pre;
      logic [7:0] ah [FRAME_CYC];
      logic [7:0] ch [FRAME_CYC];
      brightness = 2'd3;
      wr_en = 1'b1; wr_row = 3'd3; wr_data = 8'hA5;
      @(negedge clk_in); set_idle(); commit = 1'b1;
      @(negedge clk_in); commit = 1'b0;
      wait_fs(300, ok);
      checks++; if (!ok) begin errors++; $display("FAIL row3_fs_timeout got=none want=pulse"); end
      checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL row3_pending_drop got=%b want=0", commit_pending); end
      lit = 0; i0 = -1;
      for (int i = 0; i < FRAME_CYC; i++) begin
         if ({out_anode, out_cathode, frame_start, commit_pending} !== {exp_anode, exp_cathode, exp_fs, m_pending}) begin
            errors++;
            $display("FAIL row3_model n=%0d got an=%h ca=%h fs=%b cp=%b want an=%h ca=%h fs=%b cp=%b", n, out_anode, out_cathode, frame_start, commit_pending, exp_anode, exp_cathode, exp_fs, m_pending);
         end
         checks++;
         ah[i] = out_anode; ch[i] = out_cathode;
         if (out_anode === 8'h08 && out_cathode === 8'h5A) begin lit++; if (i0 < 0) i0 = i; end
         @(negedge clk_in);
      end
      checks++; if (lit != 12) begin errors++; $display("FAIL row3_lit_cycles got=%0d want=12", lit); end
      pre = 0;
      if (i0 >= 4) for (int j = i0 - 4; j < i0; j++) if (ah[j] === 8'h00 && ch[j] === 8'hFF) pre++;
      checks++; if (pre != 4) begin errors++; $display("FAIL row3_pre_blank got=%0d want=4", pre); end
   endtask

   task automatic test_brightness();
      bit ok;
      int dark_lit;
      int lit [ROWS];
      brightness = 2'd0;
      wait_fs(300, ok);
      checks++; if (!ok) begin errors++; $display("FAIL bright0_fs_timeout got=none want=pulse"); end
      dark_lit = 0;
      for (int i = 0; i < FRAME_CYC; i++) begin
         if ({out_anode, out_cathode, frame_start, commit_pending} !== {exp_anode, exp_cathode, exp_fs, m_pending}) begin
            errors++;
            $display("FAIL bright_model n=%0d got an=%h ca=%h fs=%b cp=%b want an=%h ca=%h fs=%b cp=%b", n, out_anode, out_cathode, frame_start, commit_pending, exp_anode, exp_cathode, exp_fs, m_pending);
         end
         checks++;
         if (out_anode !== 8'h00) dark_lit++;
         @(negedge clk_in);
      end
      checks++; if (dark_lit != 0) begin errors++; $display("FAIL bright0_dark got=%0d want=0", dark_lit); end
      brightness = 2'd1;
      wait_fs(300, ok);
      checks++; if (!ok) begin errors++; $display("FAIL bright1_fs_timeout got=none want=pulse"); end
      for (int r = 0; r < ROWS; r++) lit[r] = 0;
      for (int i = 0; i < FRAME_CYC; i++) begin
         for (int r = 0; r < ROWS; r++) if (out_anode === (8'd1 << r)) lit[r]++;
         @(negedge clk_in);
      end
      for (int r = 0; r < ROWS; r++) begin
         checks++; if (lit[r] != 4) begin errors++; $display("FAIL bright1_row%0d got=%0d want=4", r, lit[r]); end
      end
   endtask

   task automatic test_hold_commit();
      bit ok;
      int seen;
      brightness = 2'd3;
      wr_en = 1'b1; wr_row = 3'd0; wr_data = 8'hFF;
      @(negedge clk_in); set_idle();
      wait_fs(300, ok);
      checks++; if (!ok) begin errors++; $display("FAIL hold_fs_timeout got=none want=pulse"); end
      seen = 0;
      for (int i = 0; i < 2 * FRAME_CYC; i++) begin
         if ({out_anode, out_cathode, frame_start, commit_pending} !== {exp_anode, exp_cathode, exp_fs, m_pending}) begin
            errors++;
            $display("FAIL hold_model n=%0d got an=%h ca=%h fs=%b cp=%b want an=%h ca=%h fs=%b cp=%b", n, out_anode, out_cathode, frame_start, commit_pending, exp_anode, exp_cathode, exp_fs, m_pending);
         end
         checks++;
         if (out_anode === 8'h01 && out_cathode === 8'h00) seen++;
         @(negedge clk_in);
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL hold_uncommitted got=%0d want=0", seen); end
      commit = 1'b1;
      @(negedge clk_in); commit = 1'b0;
      checks++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL hold_pending_set got=%b want=1", commit_pending); end
      wait_fs(300, ok);
      checks++; if (!ok || commit_pending !== 1'b0) begin errors++; $display("FAIL hold_pending_drop got=%b want=0", commit_pending); end
      seen = 0;
      for (int i = 0; i < FRAME_CYC; i++) begin
         if (out_anode === 8'h01 && out_cathode === 8'h00) seen++;
         @(negedge clk_in);
      end
      checks++; if (seen != 12) begin errors++; $display("FAIL hold_committed got=%0d want=12", seen); end
   endtask

   task automatic test_swap_edge();
      int old_seen, new_seen;
      brightness = 2'd3;
      wr_en = 1'b1; wr_row = 3'd1; wr_data = 8'h3C;
      @(negedge clk_in); set_idle(); commit = 1'b1;
      @(negedge clk_in); commit = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (((n + 1) % FRAME_CYC) == 0) break;
         @(negedge clk_in);
      end
      wr_en = 1'b1; wr_row = 3'd1; wr_data = 8'h0F; commit = 1'b1;
      @(negedge clk_in); set_idle();
      checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL swap_edge_fs got=%b want=1", frame_start); end
      checks++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL swap_edge_rearm got=%b want=1", commit_pending); end
      old_seen = 0;
      for (int i = 0; i < FRAME_CYC; i++) begin
         if ({out_anode, out_cathode, frame_start, commit_pending} !== {exp_anode, exp_cathode, exp_fs, m_pending}) begin
            errors++;
            $display("FAIL swap_model n=%0d got an=%h ca=%h fs=%b cp=%b want an=%h ca=%h fs=%b cp=%b", n, out_anode, out_cathode, frame_start, commit_pending, exp_anode, exp_cathode, exp_fs, m_pending);
         end
         checks++;
         if (out_anode === 8'h02 && out_cathode === 8'hC3) old_seen++;
         @(negedge clk_in);
      end
      checks++; if (old_seen != 12) begin errors++; $display("FAIL swap_old_row1 got=%0d want=12", old_seen); end
      checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL swap_second_drop got=%b want=0", commit_pending); end
      new_seen = 0;
      for (int i = 0; i < FRAME_CYC; i++) begin
         if (out_anode === 8'h02 && out_cathode === 8'hF0) new_seen++;
         @(negedge clk_in);
      end
      checks++; if (new_seen != 12) begin errors++; $display("FAIL swap_new_row1 got=%0d want=12", new_seen); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         if ({out_anode, out_cathode, frame_start, commit_pending} !== {exp_anode, exp_cathode, exp_fs, m_pending}) begin
            errors++;
            $display("FAIL random_model n=%0d got an=%h ca=%h fs=%b cp=%b want an=%h ca=%h fs=%b cp=%b", n, out_anode, out_cathode, frame_start, commit_pending, exp_anode, exp_cathode, exp_fs, m_pending);
         end
         checks++;
         wr_en   = ($urandom_range(0, 7) == 0);
         wr_row  = 3'($urandom_range(0, 7));
         wr_data = 8'($urandom);
         commit  = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 99) == 0) brightness = 2'($urandom_range(0, 3));
         @(negedge clk_in);
      end
      set_idle();
   endtask

   task automatic test_reset_mid();
      bit found;
      int bad;
      brightness = 2'd3;
      wr_en = 1'b1; wr_row = 3'd2; wr_data = 8'hFF;
      @(negedge clk_in); set_idle(); commit = 1'b1;
      @(negedge clk_in); commit = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (out_anode === 8'h20) begin found = 1'b1; break; end
         @(negedge clk_in);
      end
      checks++; if (!found) begin errors++; $display("FAIL mid_row5_timeout got=none want=anode20"); end
      #1 reset = 1'b1;
      #1;
      checks++; if (out_anode !== 8'h00) begin errors++; $display("FAIL mid_reset_anode got=%h want=00", out_anode); end
      checks++; if (out_cathode !== 8'hFF) begin errors++; $display("FAIL mid_reset_cathode got=%h want=FF", out_cathode); end
      checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL mid_reset_pending got=%b want=0", commit_pending); end
      @(negedge clk_in); @(negedge clk_in);
      reset = 1'b0;
      @(negedge clk_in);
      checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL mid_fs_after_release got=%b want=1", frame_start); end
      bad = 0;
      for (int i = 0; i < 2 * FRAME_CYC; i++) begin
         if ({out_anode, out_cathode, frame_start, commit_pending} !== {exp_anode, exp_cathode, exp_fs, m_pending}) begin
            errors++;
            $display("FAIL mid_model n=%0d got an=%h ca=%h fs=%b cp=%b want an=%h ca=%h fs=%b cp=%b", n, out_anode, out_cathode, frame_start, commit_pending, exp_anode, exp_cathode, exp_fs, m_pending);
         end
         checks++;
         if (out_cathode !== 8'hFF) bad++;
         @(negedge clk_in);
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL mid_buffers_zero got=%0d want=0", bad); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_frame_period();
      test_row3_pattern();
      test_brightness();
      test_hold_commit();
      test_swap_edge();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
